fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Controls the program-counter register and the instruction-memory fetch port.
- Drives the PC register's stall, branch-select and target inputs.
- Handles the imem request/ready handshake with multi-cycle memory latency, decode hazard holds, taken-branch redirects from EX, HALT, and a fetch timeout.
- Sits between the PC register, the instruction memory and the IF/ID pipeline register.

Parameters:
- IMEM_TIMEOUT, 8: consecutive unanswered request cycles before the fetch error. Legal range 1..255.
- CNT_W, 8: width of the wait counter. Must hold IMEM_TIMEOUT.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: reset, asynchronous, active-low.
- pc_in, input, 16: current PC register value.
- imem_rdy, input, 1: instruction memory has data for the outstanding request this cycle.
- hazard_stall, input, 1: decode hazard unit requests a fetch hold.
- br_taken, input, 1: EX resolved a taken branch this cycle.
- br_target, input, 16: target address for br_taken.
- halt_dec, input, 1: HALT decoded this cycle.
- imem_req, output, 1: fetch request. Held high until imem_rdy.
- imem_addr, output, 16: fetch address. Always equals pc_in.
- pc_stall, output, 1: to the PC register. Hold the PC.
- pc_branch, output, 1: to the PC register. Load pc_target.
- pc_target, output, 16: branch address for the PC register.
- inst_valid, output, 1: IF/ID may capture imem data this cycle.
- flush_if, output, 1: squash the IF/ID content.
- halted, output, 1: sequencer is in HALT.
- fetch_err, output, 1: sticky timeout flag.

Behaviour:
- Reset (async, any state):
  - state goes to S_IDLE; wait counter and redirect buffer clear to 0.
  - All outputs except pc_stall deassert, and pc_target reads 0.
  - pc_stall is 1 during reset.
- Reset mid-request aborts the request; imem_req drops asynchronously.
- Outputs are Moore/Mealy as listed below; all registers update on the rising edge of clk.
- S_IDLE: imem_req=0, pc_stall=1. Goes to S_FETCH unconditionally after 1 cycle. The first request is therefore issued on cycle 2 after reset release.
- S_FETCH:
  - imem_req=1.
  - pc_stall = ~imem_rdy | hazard_stall.
  - inst_valid = imem_rdy & ~hazard_stall & ~br_taken.
  - While hazard_stall is high, the same address is re-requested.
- br_taken in S_FETCH (priority over halt_dec, hazard_stall and timeout):
  - Drive pc_branch=1, pc_target=br_target, pc_stall=0, flush_if=1, inst_valid=0 in the same cycle.
  - Clear the wait counter.
  - Behaviour when imem_rdy=0 depends on the optional feature.
- halt_dec with br_taken=0 in S_FETCH: pc_stall=1, go to S_HALT.
- S_HALT: imem_req=0, pc_stall=1, halted=1. Exits only via reset.
- Wait counter:
  - Increments each cycle that imem_req=1 and imem_rdy=0. Clears on imem_rdy or a redirect.
  - When the counter reaches IMEM_TIMEOUT, set fetch_err (sticky until reset) and go to S_HALT next cycle.
  - The counter saturates.
- pc_target equals br_target when pc_branch comes from a direct redirect, or the buffer value when it comes from S_REDIR. Otherwise it holds its last value.
- pc_branch and pc_stall are never both 1.

Optional Feature:
- Macro: FETCH_REDIR_BUF_EN.
- Defined:
  - br_taken in S_FETCH with imem_rdy=0 does not abort the request.
  - br_target latches into the redirect buffer; pc_stall=1, flush_if=1, go to S_REDIR.
  - S_REDIR: imem_req=1 at the same address, pc_stall=1, inst_valid=0. A further br_taken overwrites the buffer.
  - On imem_rdy in S_REDIR: pc_branch=1, pc_target=buffer, flush_if=1, go to S_FETCH.
  - A timeout in S_REDIR behaves as in S_FETCH.
- Undefined:
  - There is no S_REDIR and no buffer.
  - br_taken always redirects immediately, and imem_req may drop mid-transaction (abort). The memory tolerates the abort.

Test Plan:
- Release reset with imem_rdy tied 1 -> imem_req=0 and pc_stall=1 for 1 cycle, then inst_valid=1 and pc_stall=0 every cycle; PC sequence 0,1,2,3.
- imem_rdy=0 for 3 cycles at pc_in=0x0004 -> imem_req=1, imem_addr=0x0004, pc_stall=1 for 3 cycles; inst_valid=1 on the 4th.
- br_taken=1 with br_target=0x0040 while imem_rdy=1 -> same cycle pc_branch=1, pc_target=0x0040, flush_if=1, inst_valid=0.
- Macro defined; br_taken with target 0x0080 while imem_rdy=0, rdy arrives 2 cycles later -> pc_stall=1 for 2 cycles, then pc_branch=1 with pc_target=0x0080. Macro undefined: pc_branch on the br_taken cycle.
- imem_rdy held 0 with IMEM_TIMEOUT=8 -> fetch_err=1 after 8 wait cycles, then halted=1 and imem_req=0.
- halt_dec and br_taken in the same cycle -> branch taken and no halt. Later halt_dec alone -> halted=1 until rst_n pulse. Reset mid-wait -> outputs back to reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register controls and the imem request handshake.
// Optional redirect buffer (hold a taken branch until the in-flight fetch completes) enabled by FETCH_REDIR_BUF_EN.
module fetch_sequencer #(
  parameter int IMEM_TIMEOUT = 8,
  parameter int CNT_W        = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc_in,
  input  logic        imem_rdy,
  input  logic        hazard_stall,
  input  logic        br_taken,
  input  logic [15:0] br_target,
  input  logic        halt_dec,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic        pc_stall,
  output logic        pc_branch,
  output logic [15:0] pc_target,
  output logic        inst_valid,
  output logic        flush_if,
  output logic        halted,
  output logic        fetch_err
);

`ifdef FETCH_REDIR_BUF_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT, S_REDIR} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALT} state_t;
`endif

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(IMEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [15:0]      tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout;
`ifdef FETCH_REDIR_BUF_EN
  logic [15:0]      buf_q, buf_d;
`endif

  assign imem_addr = pc_in;
  assign fetch_err = err_q;
  assign timeout   = (cnt_q >= TIMEOUT);
  assign cnt_inc   = timeout ? TIMEOUT : cnt_q + 1'b1;

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    tgt_d      = tgt_q;
    imem_req   = 1'b0;
    pc_stall   = 1'b1;
    pc_branch  = 1'b0;
    pc_target  = tgt_q;
    inst_valid = 1'b0;
    flush_if   = 1'b0;
    halted     = 1'b0;
`ifdef FETCH_REDIR_BUF_EN
    buf_d      = buf_q;
`endif

    case (state_q)
      S_IDLE: state_d = S_FETCH;

      S_FETCH: begin
        imem_req   = 1'b1;
        pc_stall   = ~imem_rdy | hazard_stall;
        inst_valid = imem_rdy & ~hazard_stall & ~br_taken;
        cnt_d      = imem_rdy ? '0 : cnt_inc;
        if (br_taken) begin
          cnt_d    = '0;
          flush_if = 1'b1;
`ifdef FETCH_REDIR_BUF_EN
          if (!imem_rdy) begin
            // Keep the in-flight fetch alive; the redirect is applied once it completes.
            buf_d    = br_target;
            pc_stall = 1'b1;
            state_d  = S_REDIR;
          end else begin
            pc_branch = 1'b1;
            pc_stall  = 1'b0;
            pc_target = br_target;
            tgt_d     = br_target;
          end
`else
          pc_branch = 1'b1;
          pc_stall  = 1'b0;
          pc_target = br_target;
          tgt_d     = br_target;
`endif
        end else if (halt_dec || timeout) begin
          pc_stall = 1'b1;
          state_d  = S_HALT;
        end
      end

`ifdef FETCH_REDIR_BUF_EN
      S_REDIR: begin
        imem_req = 1'b1;
        pc_stall = 1'b1;
        cnt_d    = imem_rdy ? '0 : cnt_inc;
        if (imem_rdy) begin
          pc_branch = 1'b1;
          pc_stall  = 1'b0;
          flush_if  = 1'b1;
          pc_target = br_taken ? br_target : buf_q;
          tgt_d     = pc_target;
          state_d   = S_FETCH;
        end else if (br_taken) begin
          buf_d    = br_target;
          flush_if = 1'b1;
          cnt_d    = '0;
        end else if (timeout) begin
          state_d = S_HALT;
        end
      end
`endif

      S_HALT: halted = 1'b1;

      default: state_d = S_IDLE;
    endcase

    if (cnt_d == TIMEOUT) err_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tgt_q   <= tgt_d;
    end
  end

`ifdef FETCH_REDIR_BUF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buf_q <= '0;
    else        buf_q <= buf_d;
  end
`endif

endmodule
